// File: rtl/fib_doubling.sv
// -----------------------------------------------------------------------------
// fib_doubling
//   Computes F(n) and F(n+1) modulo 2^W with the fast-doubling recurrence.
//   One index bit is consumed per clock, MSB first, so every request takes
//   exactly NW step cycles regardless of n. out_ovf flags when the true F(n)
//   does not fit in W bits.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   request present on in_n
//   in_ready   out  1   block is IDLE and will accept a request
//   in_n       in   NW  Fibonacci index n
//   out_valid  out  1   result valid (DONE state)
//   out_ready  in   1   consumer accepts the result
//   out_fib    out  W   F(n)   mod 2^W
//   out_fib1   out  W   F(n+1) mod 2^W
//   out_ovf    out  1   1 iff the true F(n) >= 2^W
//   busy       out  1   stepping through the index bits
// -----------------------------------------------------------------------------
module fib_doubling #(
  parameter int W  = 32,
  parameter int NW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] in_n,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_fib,
  output logic [W-1:0]  out_fib1,
  output logic          out_ovf,
  output logic          busy
);

  // Smallest index whose Fibonacci number needs more than W bits.
  // W+1 bits of headroom are enough to see the first value crossing 2^W.
  function automatic int calc_nmax();
    logic [W:0] f0;
    logic [W:0] f1;
    logic [W:0] t;
    int         k;
    bit         found;
    f0    = '0;
    f1    = {{W{1'b0}}, 1'b1};
    k     = 0;
    found = 1'b0;
    for (int i = 0; i < 2 * W + 8; i++) begin
      if (!found && f0[W]) begin
        found = 1'b1;
        k     = i;
      end
      t  = f0 + f1;
      f0 = f1;
      f1 = t;
    end
    return k;
  endfunction

  localparam int NMAX = calc_nmax();
  localparam int CW   = (NW > 1) ? $clog2(NW) : 1;
  // Compare in a width that holds both in_n and NMAX; when NMAX exceeds the
  // largest representable index the comparison is simply never true.
  localparam int NE   = (NW > 32) ? NW : 32;
  localparam logic [NE:0] NMAX_EXT = (NE + 1)'(NMAX);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [NW-1:0]   r_n;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_ovf;
  logic [W-1:0]    r_fib;
  logic [W-1:0]    r_fib1;
  logic            r_ovf_out;
  logic            r_out_valid;

  logic            w_accept;
  logic            w_last;
  logic            w_bit;
  logic            w_ovf_req;
  logic [W-1:0]    w_tbma;
  logic [W-1:0]    w_c;
  logic [W-1:0]    w_d;
  logic [W-1:0]    w_cd;
  logic [W-1:0]    w_a_nxt;
  logic [W-1:0]    w_b_nxt;

  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_last    = (r_cnt == '0);
  assign w_bit     = r_n[r_cnt];
  assign w_ovf_req = ((NE + 1)'(in_n) >= NMAX_EXT);

  // Fast doubling with a=F(k), b=F(k+1):
  //   F(2k) = a*(2b-a), F(2k+1) = a^2 + b^2.
  // Ring arithmetic mod 2^W keeps the wrapped subtraction exact.
  assign w_tbma  = (r_b << 1) - r_a;
  assign w_c     = r_a * w_tbma;
  assign w_d     = r_a * r_a + r_b * r_b;
  assign w_cd    = w_c + w_d;
  assign w_a_nxt = w_bit ? w_d  : w_c;
  assign w_b_nxt = w_bit ? w_cd : w_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE:    w_state_nxt = in_valid ? RUN : IDLE;
      RUN:     w_state_nxt = w_last ? DONE : RUN;
      DONE:    w_state_nxt = out_ready ? IDLE : DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n         <= '0;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_ovf       <= 1'b0;
      r_fib       <= '0;
      r_fib1      <= '0;
      r_ovf_out   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (w_state_nxt == DONE);
      if (w_accept) begin
        r_n   <= in_n;
        r_cnt <= CW'(NW - 1);
        r_a   <= '0;
        r_b   <= {{(W-1){1'b0}}, 1'b1};
        r_ovf <= w_ovf_req;
      end else if (r_state == RUN) begin
        r_a   <= w_a_nxt;
        r_b   <= w_b_nxt;
        r_cnt <= r_cnt - CW'(1);
        if (w_last) begin
          r_fib     <= w_a_nxt;
          r_fib1    <= w_b_nxt;
          r_ovf_out <= r_ovf;
        end
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == RUN);
  assign out_valid = r_out_valid;
  assign out_fib   = r_fib;
  assign out_fib1  = r_fib1;
  assign out_ovf   = r_ovf_out;

endmodule

// File: tb/tb_fib_doubling.sv
module tb_fib_doubling;
  localparam int W  = 32;
  localparam int NW = 32;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [NW-1:0] in_n      = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_fib;
  logic [W-1:0]  out_fib1;
  logic          out_ovf;
  logic          busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  fib_doubling #(.W(W), .NW(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_n      (in_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fib   (out_fib),
    .out_fib1  (out_fib1),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts from IDLE just after an edge; returns just after the DONE edge
  // (or after the cycle budget runs out, which the latency check catches).
  task automatic request(input string tag, input logic [NW-1:0] n, output int lat);
    in_valid = 1'b1;
    in_n     = n;
    tick();
    chk({tag, "_busy"}, busy, 1);
    in_valid = 1'b0;
    in_n     = $urandom;
    lat      = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    lat = lat - 1;
  endtask

  task automatic txn(input string tag, input logic [NW-1:0] n,
                     input logic [63:0] ef, input logic [63:0] ef1, input logic eo);
    int lat;
    request(tag, n, lat);
    chk({tag, "_lat"}, lat, 32);
    chk({tag, "_fib"}, out_fib, ef);
    chk({tag, "_fib1"}, out_fib1, ef1);
    chk({tag, "_ovf"}, out_ovf, eo);
    tick();
    chk({tag, "_idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int lat;
    int acc[2];
    logic [W-1:0] res[2];
    int k;
    int r;
    logic prev;

    // Reset state
    repeat (2) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fib", out_fib, 0);
    chk("rst_fib1", out_fib1, 0);
    chk("rst_ovf", out_ovf, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("rel_in_ready", in_ready, 1);

    // Main function
    out_ready = 1'b1;
    txn("n30", 30, 832040, 1346269, 0);
    chk("n30_hold", out_fib, 832040);
    txn("n0", 0, 0, 1, 0);
    txn("n1", 1, 1, 1, 0);
    txn("n47", 47, 64'd2971215073, 64'd512559680, 0);
    txn("n48", 48, 64'd512559680, 64'd3483774753, 1);
    request("nmax", 32'hFFFF_FFFF, lat);
    chk("nmax_lat", lat, 32);
    chk("nmax_ovf", out_ovf, 1);
    tick();

    // Backpressure in DONE
    out_ready = 1'b0;
    request("bp", 20, lat);
    chk("bp_lat", lat, 32);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      in_n     = 5;
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_fib", out_fib, 6765);
      chk("bp_fib1", out_fib1, 10946);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_rel_valid", out_valid, 0);
    chk("bp_rel_in_ready", in_ready, 1);
    chk("bp_rel_hold", out_fib, 6765);
    tick();
    chk("bp_no_accept", in_ready, 1);

    // Reset during RUN step 10
    in_valid = 1'b1;
    in_n     = 30;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_fib", out_fib, 0);
    chk("mrst_fib1", out_fib1, 0);
    chk("mrst_ovf", out_ovf, 0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    txn("post_rst", 30, 832040, 1346269, 0);

    // Back-to-back with in_valid held high
    in_valid = 1'b1;
    in_n     = 10;
    prev     = 1'b0;
    k        = 0;
    r        = 0;
    for (int i = 0; i < 120 && !(k == 2 && r == 2); i++) begin
      tick();
      if (busy && !prev && k < 2) begin
        acc[k] = cyc;
        k++;
        if (k == 1) in_n = 20;
        else        in_valid = 1'b0;
      end
      if (out_valid && r < 2) begin
        res[r] = out_fib;
        r++;
      end
      prev = busy;
    end
    in_valid = 1'b0;
    chk("b2b_accepts", k, 2);
    chk("b2b_results", r, 2);
    if (k == 2 && r == 2) begin
      chk("b2b_res0", res[0], 55);
      chk("b2b_res1", res[1], 6765);
      chk("b2b_spacing", acc[1] - acc[0], 34);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
